// File: rtl/gb_cpu_interrupt_ctrl.sv
// SM83 interrupt controller: IME, HALT and the 5-M-cycle interrupt dispatch.
// Optional DMG HALT bug strobe is enabled with `define GB_HALT_BUG_EN.
module gb_cpu_interrupt_ctrl #(
  parameter int          NUM_IRQ     = 5,
  parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_boundary,
  input  logic               enable_interrupts,
  input  logic               disable_interrupts,
  input  logic               reti,
  input  logic               halt_req,
  input  logic [NUM_IRQ-1:0] if_i,
  input  logic [NUM_IRQ-1:0] ie_i,
  output logic               ime,
  output logic               dispatch_active,
  output logic [2:0]         dispatch_m_cycle,
  output logic [15:0]        irq_vector,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               halted,
  output logic               halt_bug
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_DISP = 2'd2;

  logic [1:0]         state;
  logic               ei_pending;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] lowest;
  logic               any_pending;
  logic [15:0]        vec_c;
  logic               take_irq;
  logic               halt_skip;

  // Lowest set bit has priority: scan high to low so the last hit wins.
  always_comb begin
    pending     = if_i & ie_i;
    any_pending = |pending;
    lowest      = '0;
    vec_c       = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--) begin
      if (pending[i]) begin
        lowest    = '0;
        lowest[i] = 1'b1;
        vec_c     = VECTOR_BASE + 16'(i * 8);
      end
    end
  end

  assign take_irq        = (state == ST_RUN) && instr_boundary && ime && any_pending;
  assign halt_skip       = any_pending && !ime;
  assign dispatch_active = (state == ST_DISP);
  // Combinational so the ack reflects pending as seen during step 3 itself.
  assign irq_ack         = (state == ST_DISP && dispatch_m_cycle == 3'd3) ? lowest : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_RUN;
      ime              <= 1'b0;
      ei_pending       <= 1'b0;
      dispatch_m_cycle <= 3'd0;
      irq_vector       <= 16'h0000;
      halted           <= 1'b0;
      halt_bug         <= 1'b0;
    end else begin
      halt_bug <= 1'b0;
      if (reti)              ime        <= 1'b1;
      if (enable_interrupts) ei_pending <= 1'b1;
      case (state)
        ST_RUN: begin
          if (instr_boundary && ei_pending) begin
            ime        <= 1'b1;
            ei_pending <= enable_interrupts;
          end
          if (take_irq) begin
            state            <= ST_DISP;
            dispatch_m_cycle <= 3'd0;
            ime              <= 1'b0;
            ei_pending       <= 1'b0;
          end else if (halt_req) begin
            if (halt_skip) begin
`ifdef GB_HALT_BUG_EN
              halt_bug <= !halt_bug;
`endif
            end else begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (any_pending) begin
            halted <= 1'b0;
            // A deferred EI counts as IME=1 for the wake-up decision.
            if (ime || ei_pending) begin
              state            <= ST_DISP;
              dispatch_m_cycle <= 3'd0;
              ime              <= 1'b0;
              ei_pending       <= 1'b0;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_DISP: begin
          if (dispatch_m_cycle == 3'd3) irq_vector <= vec_c;
          if (dispatch_m_cycle == 3'd4) begin
            state            <= ST_RUN;
            dispatch_m_cycle <= 3'd0;
          end else begin
            dispatch_m_cycle <= dispatch_m_cycle + 3'd1;
          end
        end
        default: state <= ST_RUN;
      endcase
      if (disable_interrupts) begin
        ime        <= 1'b0;
        ei_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Scoreboard bench for gb_cpu_interrupt_ctrl: stimulus queues expected dispatches,
// a negedge monitor checks ack/vector whenever a dispatch reaches steps 3/4.
module tb_gb_cpu_interrupt_ctrl;
  logic        clk, reset;
  logic        instr_boundary, enable_interrupts, disable_interrupts, reti, halt_req;
  logic [4:0]  if_i, ie_i;
  logic        ime, dispatch_active, halted, halt_bug;
  logic [2:0]  dispatch_m_cycle;
  logic [15:0] irq_vector;
  logic [4:0]  irq_ack;

  typedef struct packed {
    logic [4:0]  ack;
    logic [15:0] vec;
  } exp_t;

  exp_t       q[$];
  logic [4:0] ack_seen;
  int         n_checks = 0;
  int         n_err    = 0;

  gb_cpu_interrupt_ctrl dut (
    .clk(clk), .reset(reset), .instr_boundary(instr_boundary),
    .enable_interrupts(enable_interrupts), .disable_interrupts(disable_interrupts),
    .reti(reti), .halt_req(halt_req), .if_i(if_i), .ie_i(ie_i),
    .ime(ime), .dispatch_active(dispatch_active), .dispatch_m_cycle(dispatch_m_cycle),
    .irq_vector(irq_vector), .irq_ack(irq_ack), .halted(halted), .halt_bug(halt_bug)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected record per completed dispatch.
  always @(negedge clk) begin
    if (!reset) begin
      if (irq_ack != 5'b0 && !(dispatch_active && dispatch_m_cycle == 3'd3))
        chk("ack_outside_step3", {27'b0, irq_ack}, 32'h0);
      if (dispatch_active && dispatch_m_cycle == 3'd3) ack_seen = irq_ack;
      if (dispatch_active && dispatch_m_cycle == 3'd4) begin
        if (q.size() == 0) begin
          chk("unexpected_dispatch", {16'b0, irq_vector}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("irq_ack", {27'b0, ack_seen}, {27'b0, e.ack});
          chk("irq_vector", {16'b0, irq_vector}, {16'b0, e.vec});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    {instr_boundary, enable_interrupts, disable_interrupts, reti, halt_req} = '0;
    if_i = '0; ie_i = '0;
    tick(2);
    chk("rst_ime", {31'b0, ime}, 0);
    chk("rst_active", {31'b0, dispatch_active}, 0);
    chk("rst_mcycle", {29'b0, dispatch_m_cycle}, 0);
    chk("rst_vector", {16'b0, irq_vector}, 0);
    chk("rst_ack", {27'b0, irq_ack}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_halt_bug", {31'b0, halt_bug}, 0);
    reset = 1'b0;
    tick();

    // EI delay: first boundary only promotes IME, second one dispatches.
    if_i = 5'b00001; ie_i = 5'b00001;
    enable_interrupts = 1'b1; tick(); enable_interrupts = 1'b0;
    chk("ei_no_immediate", {31'b0, ime}, 0);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("ei_first_boundary_nodisp", {31'b0, dispatch_active}, 0);
    chk("ei_ime_promoted", {31'b0, ime}, 1);
    q.push_back('{ack: 5'b00001, vec: 16'h0040});
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("disp_step0", {28'b0, dispatch_active, dispatch_m_cycle}, 32'h8);
    chk("disp_clears_ime", {31'b0, ime}, 0);
    tick(6);
    chk("disp_done", {31'b0, dispatch_active}, 0);

    // Priority: lowest pending bit wins.
    if_i = 5'b10100; ie_i = 5'b11111;
    reti = 1'b1; tick(); reti = 1'b0;
    chk("reti_ime", {31'b0, ime}, 1);
    q.push_back('{ack: 5'b00100, vec: 16'h0050});
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    tick(6);
    chk("prio_ime_after", {31'b0, ime}, 0);

    // IE cleared during dispatch: vector 0, no ack.
    if_i = 5'b00001; ie_i = 5'b00001;
    reti = 1'b1; tick(); reti = 1'b0;
    q.push_back('{ack: 5'b00000, vec: 16'h0000});
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    tick();
    ie_i = 5'b0;
    tick(5);
    chk("cancel_done", {31'b0, dispatch_active}, 0);

    // Reset in step 2 aborts the dispatch without ack.
    ie_i = 5'b00001;
    reti = 1'b1; tick(); reti = 1'b0;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    tick(2);
    chk("pre_reset_step2", {28'b0, dispatch_active, dispatch_m_cycle}, 32'hA);
    reset = 1'b1; #1;
    chk("midreset_active", {31'b0, dispatch_active}, 0);
    chk("midreset_ime", {31'b0, ime}, 0);
    chk("midreset_mcycle", {29'b0, dispatch_m_cycle}, 0);
    tick();
    reset = 1'b0; if_i = '0; ie_i = '0;
    tick(3);

    // HALT with IME=0: wake to RUN, no dispatch.
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("halt_entered", {31'b0, halted}, 1);
    tick(2);
    chk("halt_held", {31'b0, halted}, 1);
    if_i = 5'b01000; ie_i = 5'b01000;
    tick();
    chk("halt_wake_ime0", {31'b0, halted}, 0);
    chk("halt_wake_nodisp", {31'b0, dispatch_active}, 0);
    tick(6);
    if_i = '0; ie_i = '0;

    // HALT with IME=1: wake into dispatch.
    reti = 1'b1; tick(); reti = 1'b0;
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("halt2_entered", {31'b0, halted}, 1);
    q.push_back('{ack: 5'b01000, vec: 16'h0058});
    if_i = 5'b01000; ie_i = 5'b01000;
    tick();
    chk("halt2_wake", {30'b0, halted, dispatch_active}, 32'h1);
    tick(6);
    if_i = '0; ie_i = '0;

    // EI while halted promotes on wake and dispatches.
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    enable_interrupts = 1'b1; tick(); enable_interrupts = 1'b0;
    chk("halt3_ime_deferred", {30'b0, ime, halted}, 32'h1);
    q.push_back('{ack: 5'b00010, vec: 16'h0048});
    if_i = 5'b00010; ie_i = 5'b00010;
    tick();
    chk("halt3_wake_disp", {30'b0, halted, dispatch_active}, 32'h1);
    tick(6);
    if_i = '0; ie_i = '0;

    // DI wins over RETI; DI clears IME.
    reti = 1'b1; disable_interrupts = 1'b1; tick();
    reti = 1'b0; disable_interrupts = 1'b0;
    chk("di_beats_reti", {31'b0, ime}, 0);
    reti = 1'b1; tick(); reti = 1'b0;
    disable_interrupts = 1'b1; tick(); disable_interrupts = 1'b0;
    chk("di_clears_ime", {31'b0, ime}, 0);

    // Dispatch beats simultaneous HALT.
    reti = 1'b1; tick(); reti = 1'b0;
    if_i = 5'b10000; ie_i = 5'b10000;
    q.push_back('{ack: 5'b10000, vec: 16'h0060});
    halt_req = 1'b1; instr_boundary = 1'b1; tick();
    halt_req = 1'b0; instr_boundary = 1'b0;
    chk("disp_over_halt", {30'b0, halted, dispatch_active}, 32'h1);
    tick(6);
    chk("disp_over_halt_end", {30'b0, halted, dispatch_active}, 32'h0);

    // HALT bug case: IME=0 with pending.
    if_i = 5'b00001; ie_i = 5'b00001;
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("hbug_not_halted", {31'b0, halted}, 0);
`ifdef GB_HALT_BUG_EN
    chk("hbug_pulse", {31'b0, halt_bug}, 1);
`else
    chk("hbug_pulse", {31'b0, halt_bug}, 0);
`endif
    tick();
    chk("hbug_single", {31'b0, halt_bug}, 0);
    chk("hbug_nodisp", {31'b0, dispatch_active}, 0);
    tick(6);

    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
